// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Opcodes, state encoding and datapath control encodings shared by
//            the multicycle MIPS controller and its testbenches.
//            Optional macro MULTI_CTRL_ADDI_EN adds the ADDI opcode and states.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    localparam logic [1:0] c_srcb_regb  = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    localparam logic [1:0] c_pc_alu    = 2'b00;
    localparam logic [1:0] c_pc_aluout = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

    typedef enum logic [3:0] {
        S_START   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
`ifdef MULTI_CTRL_ADDI_EN
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12
`else
        S_JUMP    = 4'd10
`endif
    } state_t;

    // Moore part of the control word; handshake-gated bits are applied in the top.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multi_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module   : multi_ctrl_dec
// Brief    : Combinational decode of the controller state into the Moore
//            datapath control word. Macro MULTI_CTRL_ADDI_EN adds ADDI states.
// Revision : 1.0  initial release
// ============================================================================
module multi_ctrl_dec
    import ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.memRead = 1'b1;
                o_ctrl.aluSrcB = c_srcb_four;
                o_ctrl.aluOp   = c_alu_add;
                o_ctrl.pcSrc   = c_pc_alu;
            end
            S_DECODE: begin
                o_ctrl.aluSrcB = c_srcb_immsh;
                o_ctrl.aluOp   = c_alu_add;
            end
            S_MEMADR: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = c_srcb_imm;
                o_ctrl.aluOp   = c_alu_add;
            end
            S_MEMRD: begin
                o_ctrl.memRead = 1'b1;
                o_ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.regWrite = 1'b1;
                o_ctrl.memtoReg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.memWrite = 1'b1;
                o_ctrl.iorD     = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = c_srcb_regb;
                o_ctrl.aluOp   = c_alu_funct;
            end
            S_ALUWB: begin
                o_ctrl.regWrite = 1'b1;
                o_ctrl.regDst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.aluSrcA     = 1'b1;
                o_ctrl.aluSrcB     = c_srcb_regb;
                o_ctrl.aluOp       = c_alu_sub;
                o_ctrl.pcWriteCond = 1'b1;
                o_ctrl.pcSrc       = c_pc_aluout;
            end
            S_JUMP: begin
                o_ctrl.pcWrite = 1'b1;
                o_ctrl.pcSrc   = c_pc_jump;
            end
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = c_srcb_imm;
                o_ctrl.aluOp   = c_alu_add;
            end
            S_ADDIWB: begin
                o_ctrl.regWrite = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_ctrl
// Brief    : Multicycle MIPS control FSM with memory-ready handshake, memory
//            timeout and illegal-opcode flag.
//            Macro MULTI_CTRL_ADDI_EN makes opcode 001000 (ADDI) legal.
// Revision : 1.0  initial release
// ============================================================================
module multi_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TO = 15,
    parameter int OP_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            pcWrite,
    output logic            pcWriteCond,
    output logic            iorD,
    output logic            memRead,
    output logic            memWrite,
    output logic            irWrite,
    output logic            memtoReg,
    output logic            regDst,
    output logic            regWrite,
    output logic            aluSrcA,
    output logic [1:0]      aluSrcB,
    output logic [1:0]      aluOp,
    output logic [1:0]      pcSrc,
    output logic            instr_done,
    output logic            illegal_op,
    output logic            mem_err
);

    localparam logic [7:0] c_to_last = 8'(MEM_TO - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    ctrl_t      w_ctrl;
    logic       w_waiting;
    logic       w_timeout;
    logic       w_is_fetch;
    logic       w_legal;

    assign w_is_fetch = (state_q == S_FETCH);
    assign w_waiting  = w_is_fetch || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready arriving on the final allowed cycle still completes the access.
    assign w_timeout  = w_waiting && !mem_ready && (cnt_q == c_to_last);

    assign w_legal = (op == OP_W'(c_op_rtype)) || (op == OP_W'(c_op_lw))  ||
                     (op == OP_W'(c_op_sw))    || (op == OP_W'(c_op_beq)) ||
`ifdef MULTI_CTRL_ADDI_EN
                     (op == OP_W'(c_op_addi))  ||
`endif
                     (op == OP_W'(c_op_j));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_W'(c_op_rtype))
                    state_d = S_EXECUTE;
                else if ((op == OP_W'(c_op_lw)) || (op == OP_W'(c_op_sw)))
                    state_d = S_MEMADR;
                else if (op == OP_W'(c_op_beq))
                    state_d = S_BRANCH;
                else if (op == OP_W'(c_op_j))
                    state_d = S_JUMP;
`ifdef MULTI_CTRL_ADDI_EN
                else if (op == OP_W'(c_op_addi))
                    state_d = S_ADDIEX;
`endif
                else
                    state_d = S_FETCH;
            end
            S_MEMADR: state_d = (op == OP_W'(c_op_lw)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  begin
                if (mem_ready)      state_d = S_MEMWB;
                else if (w_timeout) state_d = S_FETCH;
            end
            S_MEMWR:  begin
                if (mem_ready || w_timeout) state_d = S_FETCH;
            end
            S_EXECUTE: state_d = S_ALUWB;
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
`endif
            default:   state_d = S_FETCH;
        endcase

        // Only a continued wait in the same memory state keeps counting.
        if (w_waiting && (state_d == state_q) && !mem_ready && !w_timeout)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = 8'd0;
    end

    multi_ctrl_dec u_dec (
        .i_state (state_q),
        .o_ctrl  (w_ctrl)
    );

    always_comb begin
        pcWrite     = w_ctrl.pcWrite | (w_is_fetch & mem_ready);
        irWrite     = w_is_fetch & mem_ready;
        pcWriteCond = w_ctrl.pcWriteCond;
        iorD        = w_ctrl.iorD;
        memRead     = w_ctrl.memRead;
        memWrite    = w_ctrl.memWrite & ~w_timeout;
        memtoReg    = w_ctrl.memtoReg;
        regDst      = w_ctrl.regDst;
        regWrite    = w_ctrl.regWrite;
        aluSrcA     = w_ctrl.aluSrcA;
        aluSrcB     = w_ctrl.aluSrcB;
        aluOp       = w_ctrl.aluOp;
        pcSrc       = w_ctrl.pcSrc;
        illegal_op  = (state_q == S_DECODE) & ~w_legal;
        mem_err     = w_timeout;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: instr_done = 1'b1;
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIWB:                           instr_done = 1'b1;
`endif
            S_MEMWR:                            instr_done = mem_ready;
            default:                            instr_done = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/multi_ctrl.md
Name: multi_ctrl

Overview:
Multicycle MIPS control FSM: sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch/decode/execute/memory/writeback steps for R_TYPE, LW, SW, BEQ and J. It replaces the single-cycle ctrl decode for the multicycle core variant, adds a memory ready handshake with timeout, and flags illegal opcodes. Sits between the IR opcode field and the datapath mux/write-enable controls.

Parameters:
MEM_TO, 15, max cycles waiting for mem_ready in a memory state before abort (1..255)
OP_W, 6, opcode width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  OP_W  opcode from IR[31:26], stable from DECODE until the next FETCH
mem_ready  in  1  memory completes the current access this cycle
pcWrite  out  1  unconditional PC write
pcWriteCond  out  1  PC write if ALU zero (branch)
iorD  out  1  memory address: 0=PC, 1=ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  load IR from memory data
memtoReg  out  1  writeback data: 0=ALUOut, 1=MDR
regDst  out  1  dest reg: 0=rt, 1=rd
regWrite  out  1  register file write
aluSrcA  out  1  0=PC, 1=reg A
aluSrcB  out  2  00=reg B, 01=const 4, 10=signext imm, 11=signext imm<<2
aluOp  out  2  00=add, 01=sub, 10=use funct
pcSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse on final cycle of each instruction
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Opcodes: R_TYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010.
- Moore outputs decoded from registered state; exceptions: irWrite/pcWrite in FETCH and all pulses are gated combinationally by mem_ready/op as stated.
- Reset: state=START, wait counter=0. All outputs 0 in START. START -> FETCH unconditionally after reset release.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00; irWrite=pcWrite=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute). Next: LW/SW->MEMADR, R_TYPE->EXECUTE, BEQ->BRANCH, J->JUMP, other->FETCH with illegal_op=1 that cycle (no register/memory/PC write).
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. LW->MEMRD, SW->MEMWR.
- MEMRD: memRead=1, iorD=1; on mem_ready -> MEMWB.
- MEMWB: regWrite=1, memtoReg=1, regDst=0, instr_done=1 -> FETCH.
- MEMWR: memWrite=1, iorD=1; on mem_ready -> FETCH with instr_done=1.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB.
- ALUWB: regWrite=1, regDst=1, memtoReg=0, instr_done=1 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSrc=01, instr_done=1 -> FETCH.
- JUMP: pcWrite=1, pcSrc=10, instr_done=1 -> FETCH.
- Latency (mem_ready immediate): R 4, LW 5, SW 4, BEQ 3, J 3 cycles.
- Timeout: counter clears on entry to FETCH/MEMRD/MEMWR, increments each cycle waiting without mem_ready. mem_ready on the same cycle the count reaches MEM_TO completes normally (ready wins). When count reaches MEM_TO without ready: mem_err=1, next state FETCH; no write enables asserted that cycle; instr_done not pulsed. FETCH timeout re-enters FETCH (PC unchanged).
- rst_n low mid-instruction: immediate return to START, outputs 0; no partial write completes.

Optional Feature:
MULTI_CTRL_ADDI_EN: when defined, opcode 001000 (ADDI) is legal: DECODE->ADDIEX (aluSrcA=1, aluSrcB=10, aluOp=00) -> ADDIWB (regWrite=1, regDst=0, memtoReg=0, instr_done=1) -> FETCH; 4 cycles. When undefined, 001000 is illegal (illegal_op pulse, return to FETCH), and ADDIEX/ADDIWB states do not exist.

Decomposition:
- Shared package ctrl_pkg: opcode constants, state encoding, aluOp/aluSrcB/pcSrc encodings; also used by ctrl and testbenches.
- Sub-module multi_ctrl_dec: combinational state->control-vector decode; the FSM/timeout logic stays in multi_ctrl.

Test Plan:
- Reset held, then released with mem_ready=1, op=R_TYPE -> all outputs 0 during reset/START; FETCH irWrite=pcWrite=1; ALUWB regWrite=1, regDst=1; instr_done 4 cycles after FETCH entry.
- op=LW with mem_ready low 3 cycles in MEMRD -> memRead=iorD=1 held 4 cycles; MEMWB memtoReg=1, regWrite=1; no mem_err.
- op=SW, BEQ, J sequences with mem_ready=1 -> memWrite in MEMWR; BRANCH pcWriteCond=1, aluOp=01, pcSrc=01; JUMP pcWrite=1, pcSrc=10; latencies 4/3/3.
- op=111111 -> illegal_op pulse in DECODE, next state FETCH, no regWrite/memWrite/pcWrite.
- MEM_TO=3, mem_ready held low in MEMWR -> mem_err after 3 waiting cycles, memWrite drops, FETCH next; repeat with mem_ready rising on the 3rd cycle -> normal completion, no mem_err.
- rst_n asserted in MEMRD -> outputs 0 immediately; op=001000 with/without MULTI_CTRL_ADDI_EN -> ADDIWB regWrite=1 vs illegal_op pulse.
